// File: rtl/pipibibs_shram_m68k_port.sv
// pipibibs_shram_m68k_port: 68k-side byte port of the sound shared RAM with Z80 arbitration and DTACK.
// Optional watchdog on Z80 contention enabled by `define SHRAM_WDOG_EN.
module pipibibs_shram_m68k_port #(
  parameter int AW          = 11,
  parameter int WDOG_CYCLES = 255
) (
  input  logic          CLK96,
  input  logic          RESET96_N,
  input  logic          M68K_CS,
  input  logic          M68K_RNW,
  input  logic          M68K_LDS_N,
  input  logic [AW-1:0] M68K_ADDR,
  input  logic [7:0]    M68K_DIN,
  output logic [15:0]   M68K_DOUT,
  output logic          M68K_DTACK_N,
  input  logic          Z80_BUSY,
  output logic [AW-1:0] RAM_ADDR,
  output logic [7:0]    RAM_DIN,
  output logic          RAM_WE,
  input  logic [7:0]    RAM_Q,
  output logic          WDOG_HIT
);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCESS, S_LATCH, S_ACK} state_t;
  state_t        r_state;
  logic [15:0]   r_dout;
  logic          r_dtack_n;
  logic [AW-1:0] r_addr;
  logic [7:0]    r_din;
  logic          r_we;
  logic          w_issue;
  // Z80 priority is only honoured before issue; IDLE and WAIT issue identically
  assign w_issue = (r_state == S_IDLE || r_state == S_WAIT) && M68K_CS && !Z80_BUSY;
  assign M68K_DOUT    = r_dout;
  assign M68K_DTACK_N = r_dtack_n;
  assign RAM_ADDR     = r_addr;
  assign RAM_DIN      = r_din;
  assign RAM_WE       = r_we;
`ifdef SHRAM_WDOG_EN
  logic [7:0] r_cnt;
  logic       r_wdog;
  assign WDOG_HIT = r_wdog;
`else
  assign WDOG_HIT = 1'b0;
`endif
  always_ff @(posedge CLK96 or negedge RESET96_N) begin
    if (!RESET96_N) begin
      r_state   <= S_IDLE;
      r_dout    <= 16'hFFFF;
      r_dtack_n <= 1'b1;
      r_addr    <= '0;
      r_din     <= '0;
      r_we      <= 1'b0;
`ifdef SHRAM_WDOG_EN
      r_cnt     <= '0;
      r_wdog    <= 1'b0;
`endif
    end else begin
`ifdef SHRAM_WDOG_EN
      r_wdog <= 1'b0;
`endif
      if (w_issue) begin
        r_addr  <= M68K_ADDR;
        r_din   <= M68K_DIN;
        r_we    <= !M68K_RNW && !M68K_LDS_N;
        r_state <= S_ACCESS;
      end else begin
        case (r_state)
          S_IDLE: if (M68K_CS) begin
            r_state <= S_WAIT;
`ifdef SHRAM_WDOG_EN
            r_cnt   <= '0;
`endif
          end
          S_WAIT: if (!M68K_CS) r_state <= S_IDLE;
`ifdef SHRAM_WDOG_EN
          else if (r_cnt == 8'(WDOG_CYCLES)) begin
            r_wdog    <= 1'b1;
            r_dout    <= 16'hFFFF;
            r_dtack_n <= 1'b0;
            r_state   <= S_ACK;
          end else r_cnt <= r_cnt + 8'd1;
`endif
          S_ACCESS: begin
            r_we    <= 1'b0;
            r_state <= M68K_CS ? S_LATCH : S_IDLE;
          end
          S_LATCH: if (M68K_CS) begin
            r_dout    <= {8'hFF, RAM_Q};
            r_dtack_n <= 1'b0;
            r_state   <= S_ACK;
          end else r_state <= S_IDLE;
          S_ACK: if (!M68K_CS) begin
            r_dtack_n <= 1'b1;
            r_state   <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pipibibs_shram_m68k_port.sv
// tb_pipibibs_shram_m68k_port: table-driven bench with a registered BRAM model and a DOUT scoreboard.
module tb_pipibibs_shram_m68k_port;
  localparam int AW = 11;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cs = 1'b0, rnw = 1'b1, lds_n = 1'b1, busy = 1'b0;
  logic [AW-1:0] addr = '0, ram_addr;
  logic [7:0] din = '0, ram_din, ram_q;
  logic [15:0] dout;
  logic dtack_n, ram_we, wdog_hit;
  logic [7:0] mem [2**AW];
  logic [7:0] ref_mem [2**AW];
  int checks = 0, failures = 0;
  int we_cnt = 0, we_busy_viol = 0, we_double = 0, wdog_cnt = 0;
  logic prev_busy = 1'b0, prev_we = 1'b0;
  logic [AW-1:0] last_we_addr;
  logic [7:0] last_we_din;
  logic [15:0] sb_q[$];
  always #5 clk = ~clk;
  pipibibs_shram_m68k_port #(.AW(AW), .WDOG_CYCLES(16)) dut (
    .CLK96(clk), .RESET96_N(rst_n), .M68K_CS(cs), .M68K_RNW(rnw), .M68K_LDS_N(lds_n),
    .M68K_ADDR(addr), .M68K_DIN(din), .M68K_DOUT(dout), .M68K_DTACK_N(dtack_n),
    .Z80_BUSY(busy), .RAM_ADDR(ram_addr), .RAM_DIN(ram_din), .RAM_WE(ram_we),
    .RAM_Q(ram_q), .WDOG_HIT(wdog_hit));
  // Read-first registered BRAM
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_q <= mem[ram_addr];
  end
  always @(posedge clk) begin
    if (ram_we) begin
      we_cnt <= we_cnt + 1;
      last_we_addr <= ram_addr;
      last_we_din <= ram_din;
      if (prev_busy) we_busy_viol <= we_busy_viol + 1;
      if (prev_we) we_double <= we_double + 1;
    end
    if (wdog_hit) wdog_cnt <= wdog_cnt + 1;
    prev_busy <= busy;
    prev_we <= ram_we;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  typedef struct {
    logic rnw;
    logic lds_n;
    logic [AW-1:0] addr;
    logic [7:0] din;
    int busy_pre;
  } vec_t;
  vec_t vecs[10];
  task automatic access(input vec_t v);
    int n = 0, we0;
    logic [15:0] e;
    @(negedge clk);
    we0 = we_cnt;
    cs = 1'b1; rnw = v.rnw; lds_n = v.lds_n; addr = v.addr; din = v.din;
    busy = (v.busy_pre > 0);
    sb_q.push_back({8'hFF, ref_mem[v.addr]});
    if (!v.rnw && !v.lds_n) ref_mem[v.addr] = v.din;
    while (n < 300) begin
      @(posedge clk); #1;
      n++;
      if (n >= v.busy_pre) busy = 1'b0;
      if (!dtack_n) break;
    end
    chk("dtack_timeout", 32'(dtack_n), 0);
    chk("latency", n, v.busy_pre + 3);
    e = sb_q.pop_front();
    chk("dout", 32'(dout), 32'(e));
    chk("we_count", we_cnt - we0, (!v.rnw && !v.lds_n) ? 1 : 0);
    if (!v.rnw && !v.lds_n) begin
      chk("we_addr", 32'(last_we_addr), 32'(v.addr));
      chk("we_din", 32'(last_we_din), 32'(v.din));
    end
    cs = 1'b0;
    @(posedge clk); #1;
    chk("dtack_release", 32'(dtack_n), 1);
  endtask
  task automatic watch_no_dtack(input int cycles, input string name);
    int low = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (!dtack_n) low++;
    end
    chk(name, low, 0);
  endtask
  initial begin
    int we0;
    for (int i = 0; i < 2**AW; i++) begin
      mem[i] = 8'(i) ^ 8'h5A;
      ref_mem[i] = 8'(i) ^ 8'h5A;
    end
    vecs = '{
      '{1'b0, 1'b0, 11'h123, 8'hA5, 0},
      '{1'b1, 1'b0, 11'h123, 8'h00, 0},
      '{1'b0, 1'b1, 11'h010, 8'h3C, 0},
      '{1'b1, 1'b0, 11'h010, 8'h00, 0},
      '{1'b0, 1'b0, 11'h2AA, 8'h11, 5},
      '{1'b1, 1'b0, 11'h2AA, 8'h00, 2},
      '{1'b1, 1'b0, 11'h000, 8'h00, 0},
      '{1'b0, 1'b0, 11'h000, 8'hFF, 1},
      '{1'b1, 1'b0, 11'h000, 8'h00, 3},
      '{1'b1, 1'b1, 11'h7FE, 8'h00, 0}
    };
    #12;
    chk("rst_dtack", 32'(dtack_n), 1);
    chk("rst_dout", 32'(dout), 32'hFFFF);
    chk("rst_addr", 32'(ram_addr), 0);
    chk("rst_din", 32'(ram_din), 0);
    chk("rst_we", 32'(ram_we), 0);
    chk("rst_wdog", 32'(wdog_hit), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    foreach (vecs[i]) access(vecs[i]);
    // Z80 busy already before CS rises, then 3 more cycles with CS
    @(negedge clk); busy = 1'b1; we0 = we_cnt;
    repeat (2) @(posedge clk);
    access('{1'b0, 1'b0, 11'h321, 8'h5C, 3});
    access('{1'b1, 1'b0, 11'h321, 8'h00, 0});
    // Abort in WAIT
    @(negedge clk); we0 = we_cnt;
    busy = 1'b1; cs = 1'b1; rnw = 1'b0; lds_n = 1'b0; addr = 11'h055; din = 8'hEE;
    watch_no_dtack(3, "wait_abort_dtack_a");
    cs = 1'b0;
    @(posedge clk); #1; busy = 1'b0;
    watch_no_dtack(4, "wait_abort_dtack_b");
    chk("wait_abort_we", we_cnt - we0, 0);
    access('{1'b1, 1'b0, 11'h055, 8'h00, 0});
    // Abort in LATCH: write is kept
    @(negedge clk); we0 = we_cnt;
    cs = 1'b1; rnw = 1'b0; lds_n = 1'b0; addr = 11'h7FF; din = 8'h77;
    repeat (2) @(posedge clk);
    #1; cs = 1'b0;
    ref_mem[11'h7FF] = 8'h77;
    watch_no_dtack(4, "latch_abort_dtack");
    chk("latch_abort_we", we_cnt - we0, 1);
    access('{1'b1, 1'b0, 11'h7FF, 8'h00, 0});
    // Async reset while in ACK
    @(negedge clk);
    cs = 1'b1; rnw = 1'b1; lds_n = 1'b0; addr = 11'h123;
    repeat (4) @(posedge clk);
    #1; chk("pre_reset_dtack", 32'(dtack_n), 0);
    #2; rst_n = 1'b0;
    #1;
    chk("async_rst_dtack", 32'(dtack_n), 1);
    chk("async_rst_dout", 32'(dout), 32'hFFFF);
    cs = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    access('{1'b1, 1'b0, 11'h123, 8'h00, 0});
`ifdef SHRAM_WDOG_EN
    begin
      int n = 0;
      @(negedge clk); we0 = we_cnt;
      busy = 1'b1; cs = 1'b1; rnw = 1'b0; lds_n = 1'b0; addr = 11'h400; din = 8'h99;
      while (n < 100 && !wdog_hit) begin
        @(posedge clk); #1; n++;
      end
      chk("wdog_pulse", 32'(wdog_hit), 1);
      chk("wdog_dtack", 32'(dtack_n), 0);
      chk("wdog_dout", 32'(dout), 32'hFFFF);
      @(posedge clk); #1;
      chk("wdog_pulse_width", 32'(wdog_hit), 0);
      chk("wdog_we", we_cnt - we0, 0);
      cs = 1'b0;
      @(posedge clk); #1; busy = 1'b0;
      chk("wdog_release", 32'(dtack_n), 1);
      access('{1'b1, 1'b0, 11'h400, 8'h00, 0});
    end
    chk("wdog_hits", wdog_cnt, 1);
`else
    chk("wdog_hits", wdog_cnt, 0);
`endif
    chk("we_while_busy", we_busy_viol, 0);
    chk("we_multi_cycle", we_double, 0);
    chk("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
